// File: rtl/free_list_ckpt.sv
// rtl/free_list_ckpt.sv - physical register free list with branch checkpoints
//
// Purpose:
//   Tracks busy/free physical registers for the rename stage. Grants up to
//   RENAME_WIDTH lowest-indexed free registers per cycle (all-or-nothing),
//   keeps an architectural bitmap for full flush recovery, and CKPT_NUM
//   branch snapshots for selective restore. Commit frees/retires proceed
//   regardless of rename stall.
//
// Optional feature macro: FREE_LIST_DOUBLE_FREE_CHECK_EN
//   Defined   -> o_double_free is a sticky flag raised on a free of a register
//                that is already free in the live list, or a repeated index
//                among one cycle's frees.
//   Undefined -> o_double_free is tied to 0.
//
// Ports:
//   i_clock           rising-edge clock
//   i_reset           asynchronous active-low reset
//   i_stall           rename stalled: blocks allocation and checkpoint take
//   i_flush           live list <= architectural list
//   i_free_valid/prf  commit lanes freeing previous mappings
//   i_retire_valid/prf commit lanes making destinations architectural
//   i_alloc_req       per-lane allocation request
//   o_alloc_prf       granted register per lane (0 when not granted)
//   o_alloc_ok        all requests grantable this cycle
//   i_ckpt_take/_id   snapshot next live list into a slot
//   i_ckpt_restore/_id restore live list from a slot
//   o_free_count      number of free registers in the live list
//   o_double_free     sticky double-free error

module free_list_ckpt #(
    parameter int PRF_SIZE     = 64,
    parameter int ARCH_REGS    = 32,
    parameter int RENAME_WIDTH = 4,
    parameter int COMMIT_WIDTH = 4,
    parameter int CKPT_NUM     = 4,
    localparam int PIDX        = $clog2(PRF_SIZE),
    localparam int CIDX        = $clog2(CKPT_NUM)
) (
    input  logic                                   i_clock,
    input  logic                                   i_reset,
    input  logic                                   i_stall,
    input  logic                                   i_flush,
    input  logic [COMMIT_WIDTH-1:0]                i_free_valid,
    input  logic [COMMIT_WIDTH-1:0][PIDX-1:0]      i_free_prf,
    input  logic [COMMIT_WIDTH-1:0]                i_retire_valid,
    input  logic [COMMIT_WIDTH-1:0][PIDX-1:0]      i_retire_prf,
    input  logic [RENAME_WIDTH-1:0]                i_alloc_req,
    output logic [RENAME_WIDTH-1:0][PIDX-1:0]      o_alloc_prf,
    output logic                                   o_alloc_ok,
    input  logic                                   i_ckpt_take,
    input  logic [CIDX-1:0]                        i_ckpt_take_id,
    input  logic                                   i_ckpt_restore,
    input  logic [CIDX-1:0]                        i_ckpt_restore_id,
    output logic [PIDX:0]                          o_free_count,
    output logic                                   o_double_free
);

    localparam logic [PRF_SIZE-1:0] L_RESET_MAP =
        {{(PRF_SIZE-ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};
    localparam logic [PIDX:0] L_PRF_SIZE = (PIDX+1)'(PRF_SIZE);
    localparam logic [PIDX:0] L_ONE      = (PIDX+1)'(1);

    logic [PRF_SIZE-1:0]               r_live;
    logic [PRF_SIZE-1:0]               r_arch;
    logic [CKPT_NUM-1:0][PRF_SIZE-1:0] r_ckpt;
    logic [CKPT_NUM-1:0]               r_ckpt_vld;

    logic [PRF_SIZE-1:0]               w_avail;
    logic [PRF_SIZE-1:0]               w_grant;
    logic [RENAME_WIDTH-1:0][PIDX-1:0] w_lane_prf;
    logic [PIDX:0]                     w_req_cnt;
    logic [PIDX:0]                     w_busy_cnt;
    logic                              w_found;
    logic                              w_alloc_ok;
    logic [PRF_SIZE-1:0]               w_free_mask;
    logic [PRF_SIZE-1:0]               w_arch_next;
    logic [PRF_SIZE-1:0]               w_live_next;
    logic                              w_restore_hit;
    logic                              w_take;

    assign w_busy_cnt   = (PIDX+1)'($countones(r_live));
    assign o_free_count = L_PRF_SIZE - w_busy_cnt;

    // Lanes claim free indices in ascending order; each claim removes the
    // index from w_avail so later lanes see the next-lowest free register.
    always_comb begin
        w_avail    = ~r_live;
        w_grant    = '0;
        w_lane_prf = '0;
        w_req_cnt  = '0;
        w_found    = 1'b0;
        for (int l = 0; l < RENAME_WIDTH; l++) begin
            if (i_alloc_req[l]) begin
                w_req_cnt = w_req_cnt + L_ONE;
                w_found   = 1'b0;
                for (int p = 0; p < PRF_SIZE; p++) begin
                    if (!w_found && w_avail[p]) begin
                        w_lane_prf[l] = PIDX'(p);
                        w_avail[p]    = 1'b0;
                        w_grant[p]    = 1'b1;
                        w_found       = 1'b1;
                    end
                end
            end
        end
    end

    assign w_alloc_ok  = (w_req_cnt <= o_free_count);
    assign o_alloc_ok  = w_alloc_ok;
    assign o_alloc_prf = w_alloc_ok ? w_lane_prf : '0;

    // Commit lanes applied in order: a lane's free precedes its retire.
    always_comb begin
        w_free_mask = '0;
        w_arch_next = r_arch;
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            if (i_free_valid[c]) begin
                w_free_mask[i_free_prf[c]] = 1'b1;
                w_arch_next[i_free_prf[c]] = 1'b0;
            end
            if (i_retire_valid[c]) begin
                w_arch_next[i_retire_prf[c]] = 1'b1;
            end
        end
    end

    assign w_restore_hit = i_ckpt_restore && r_ckpt_vld[i_ckpt_restore_id];
    assign w_take        = i_ckpt_take && !i_stall && !i_flush && !i_ckpt_restore;

    // Any restore request (even to an invalid slot) discards allocation.
    always_comb begin
        w_live_next = r_live & ~w_free_mask;
        if (i_flush) begin
            w_live_next = w_arch_next;
        end else if (w_restore_hit) begin
            w_live_next = r_ckpt[i_ckpt_restore_id] & ~w_free_mask;
        end else if (!i_ckpt_restore && !i_stall && w_alloc_ok) begin
            w_live_next = w_live_next | w_grant;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_live     <= L_RESET_MAP;
            r_arch     <= L_RESET_MAP;
            r_ckpt     <= '0;
            r_ckpt_vld <= '0;
        end else begin
            r_live <= w_live_next;
            r_arch <= w_arch_next;
            for (int k = 0; k < CKPT_NUM; k++) begin
                if (w_take && i_ckpt_take_id == CIDX'(k)) begin
                    r_ckpt[k]     <= w_live_next;
                    r_ckpt_vld[k] <= 1'b1;
                end else begin
                    // Freed registers must not come back busy on a restore.
                    r_ckpt[k]     <= r_ckpt[k] & ~w_free_mask;
                    r_ckpt_vld[k] <= r_ckpt_vld[k] && !i_flush;
                end
            end
        end
    end

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    logic [PRF_SIZE-1:0] w_seen;
    logic                w_df_hit;
    logic                r_double_free;

    always_comb begin
        w_seen   = '0;
        w_df_hit = 1'b0;
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            if (i_free_valid[c]) begin
                if (!r_live[i_free_prf[c]] || w_seen[i_free_prf[c]]) begin
                    w_df_hit = 1'b1;
                end
                w_seen[i_free_prf[c]] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_double_free <= 1'b0;
        end else if (w_df_hit) begin
            r_double_free <= 1'b1;
        end
    end

    assign o_double_free = r_double_free;
`else
    assign o_double_free = 1'b0;
`endif

endmodule

// File: tb/tb_free_list_ckpt.sv
// tb/tb_free_list_ckpt.sv - self-checking bench for free_list_ckpt
module tb_free_list_ckpt;

    localparam int PRF  = 64;
    localparam int ARCH = 32;
    localparam int RW   = 4;
    localparam int CW   = 4;
    localparam int CK   = 4;

    typedef bit map_t [PRF];

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            stall, flush;
    logic [CW-1:0]   free_valid, retire_valid;
    logic [CW-1:0][5:0] free_prf, retire_prf;
    logic [RW-1:0]   alloc_req;
    logic [RW-1:0][5:0] alloc_prf;
    logic            alloc_ok;
    logic            ckpt_take, ckpt_restore;
    logic [1:0]      take_id, restore_id;
    logic [6:0]      free_count;
    logic            double_free;

    free_list_ckpt #(
        .PRF_SIZE(PRF), .ARCH_REGS(ARCH), .RENAME_WIDTH(RW),
        .COMMIT_WIDTH(CW), .CKPT_NUM(CK)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_stall(stall), .i_flush(flush),
        .i_free_valid(free_valid), .i_free_prf(free_prf),
        .i_retire_valid(retire_valid), .i_retire_prf(retire_prf),
        .i_alloc_req(alloc_req), .o_alloc_prf(alloc_prf), .o_alloc_ok(alloc_ok),
        .i_ckpt_take(ckpt_take), .i_ckpt_take_id(take_id),
        .i_ckpt_restore(ckpt_restore), .i_ckpt_restore_id(restore_id),
        .o_free_count(free_count), .o_double_free(double_free)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: sets of busy registers as plain bit arrays.
    map_t m_live, m_arch;
    map_t m_ck [CK];
    bit   m_vld [CK];
    bit   m_df;
    int   fq[$];
    int   exp_prf [RW];
    bit   exp_ok;
    int   exp_n;

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    localparam bit DF_EN = 1'b1;
`else
    localparam bit DF_EN = 1'b0;
`endif

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        stall = 0; flush = 0; free_valid = '0; free_prf = '0;
        retire_valid = '0; retire_prf = '0; alloc_req = '0;
        ckpt_take = 0; take_id = '0; ckpt_restore = 0; restore_id = '0;
    endtask

    task automatic model_reset();
        for (int p = 0; p < PRF; p++) begin
            m_live[p] = (p < ARCH);
            m_arch[p] = (p < ARCH);
        end
        for (int k = 0; k < CK; k++) m_vld[k] = 0;
        m_df = 0;
    endtask

    // Free list as an ascending queue; the k-th requester takes fq[k].
    task automatic build_exp();
        int k;
        fq.delete();
        for (int p = 0; p < PRF; p++) if (!m_live[p]) fq.push_back(p);
        exp_n = 0;
        for (int l = 0; l < RW; l++) if (alloc_req[l]) exp_n++;
        exp_ok = (exp_n <= fq.size());
        k = 0;
        for (int l = 0; l < RW; l++) begin
            exp_prf[l] = 0;
            if (alloc_req[l] && exp_ok) begin
                exp_prf[l] = fq[k];
                k++;
            end
        end
    endtask

    task automatic model_step();
        map_t fm;
        map_t nl;
        for (int p = 0; p < PRF; p++) fm[p] = 0;
        for (int c = 0; c < CW; c++) begin
            if (free_valid[c]) begin
                if (!m_live[free_prf[c]] || fm[free_prf[c]]) m_df = DF_EN;
                fm[free_prf[c]] = 1;
                m_arch[free_prf[c]] = 0;
            end
            if (retire_valid[c]) m_arch[retire_prf[c]] = 1;
        end
        if (flush) begin
            nl = m_arch;
        end else if (ckpt_restore && m_vld[restore_id]) begin
            nl = m_ck[restore_id];
            for (int p = 0; p < PRF; p++) if (fm[p]) nl[p] = 0;
        end else begin
            nl = m_live;
            for (int p = 0; p < PRF; p++) if (fm[p]) nl[p] = 0;
            if (!ckpt_restore && !stall && exp_ok)
                for (int k = 0; k < exp_n; k++) nl[fq[k]] = 1;
        end
        for (int k = 0; k < CK; k++)
            for (int p = 0; p < PRF; p++) if (fm[p]) m_ck[k][p] = 0;
        if (flush) begin
            for (int k = 0; k < CK; k++) m_vld[k] = 0;
        end else if (ckpt_take && !stall && !ckpt_restore) begin
            m_ck[take_id] = nl;
            m_vld[take_id] = 1;
        end
        m_live = nl;
    endtask

    task automatic tick();
        #1;
        build_exp();
        check("free_count", free_count, fq.size());
        check("alloc_ok", alloc_ok, exp_ok);
        for (int l = 0; l < RW; l++)
            check($sformatf("alloc_prf[%0d]", l), alloc_prf[l], exp_prf[l]);
        check("double_free", double_free, m_df);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst_n = 0;
        #1;
        model_reset();
        check("rst_free_count", free_count, PRF - ARCH);
        check("rst_double_free", double_free, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        idle();
        // 1: four lanes from reset
        do_reset();
        alloc_req = 4'b1111;
        #1;
        check("t1_ok", alloc_ok, 1);
        for (int l = 0; l < RW; l++) check("t1_prf", alloc_prf[l], 32 + l);
        tick();
        idle();
        #1 check("t1_count", free_count, 28);

        // 2: sparse lanes
        do_reset();
        alloc_req = 4'b1010;
        #1;
        check("t2_l0", alloc_prf[0], 0);
        check("t2_l1", alloc_prf[1], 32);
        check("t2_l2", alloc_prf[2], 0);
        check("t2_l3", alloc_prf[3], 33);
        tick();
        idle();
        #1 check("t2_count", free_count, 30);

        // 3: exhaustion, then free under stall
        do_reset();
        for (int i = 0; i < 8; i++) begin alloc_req = 4'b1111; tick(); end
        alloc_req = 4'b0001;
        #1;
        check("t3_ok", alloc_ok, 0);
        check("t3_prf", alloc_prf[0], 0);
        tick();
        idle();
        stall = 1; alloc_req = 4'b0001; free_valid = 4'b0001; free_prf[0] = 6'd40;
        tick();
        idle();
        #1 check("t3_count", free_count, 1);
        alloc_req = 4'b0001;
        #1 check("t3_regrant", alloc_prf[0], 40);
        tick();

        // 4: checkpoint take then restore
        do_reset();
        alloc_req = 4'b1111; ckpt_take = 1; take_id = 2;
        tick();
        idle(); alloc_req = 4'b1111;
        tick();
        idle(); ckpt_restore = 1; restore_id = 2;
        tick();
        idle();
        #1 check("t4_count", free_count, 28);
        alloc_req = 4'b0001;
        #1 check("t4_grant", alloc_prf[0], 36);
        tick();

        // 5: frees reach checkpoints; invalid slot restore is inert
        do_reset();
        ckpt_take = 1; take_id = 1;
        tick();
        idle(); tick();
        free_valid = 4'b0001; free_prf[0] = 6'd5;
        tick();
        idle(); ckpt_restore = 1; restore_id = 1;
        tick();
        idle();
        #1 check("t5_count", free_count, 33);
        alloc_req = 4'b0001;
        #1 check("t5_grant", alloc_prf[0], 5);
        alloc_req = 4'b1111; ckpt_restore = 1; restore_id = 3;
        tick();
        idle();
        #1 check("t5_inert", free_count, 33);

        // 6: flush restores architectural map and kills checkpoints
        do_reset();
        retire_valid = 4'b0001; retire_prf[0] = 6'd32;
        free_valid = 4'b0001; free_prf[0] = 6'd5;
        ckpt_take = 1; take_id = 0;
        tick();
        idle(); flush = 1; alloc_req = 4'b1111;
        tick();
        idle();
        #1 check("t6_count", free_count, 32);
        alloc_req = 4'b1111;
        #1;
        check("t6_l0", alloc_prf[0], 5);
        check("t6_l1", alloc_prf[1], 33);
        alloc_req = 4'b0000; ckpt_restore = 1; restore_id = 0;
        tick();
        idle();
        #1 check("t6_ckpt_dead", free_count, 32);
        free_valid = 4'b0001; free_prf[0] = 6'd5;
        tick();
        idle();
        #1 check("t6_double_free", double_free, DF_EN);
        tick();

        // Random traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int bq[$];
            int idx;
            idle();
            for (int p = 0; p < PRF; p++) if (m_live[p]) bq.push_back(p);
            stall        = ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 31) == 0);
            ckpt_restore = ($urandom_range(0, 11) == 0);
            restore_id   = 2'($urandom_range(0, CK-1));
            ckpt_take    = ($urandom_range(0, 5) == 0);
            take_id      = 2'($urandom_range(0, CK-1));
            alloc_req    = 4'($urandom_range(0, 15));
            for (int c = 0; c < CW; c++) begin
                if (bq.size() > 0 && $urandom_range(0, 9) < 4) begin
                    idx = $urandom_range(0, bq.size() - 1);
                    free_valid[c] = 1;
                    free_prf[c] = 6'(bq[idx]);
                    bq.delete(idx);
                end
            end
            for (int c = 0; c < CW; c++) begin
                if (bq.size() > 0 && $urandom_range(0, 9) < 3) begin
                    idx = $urandom_range(0, bq.size() - 1);
                    retire_valid[c] = 1;
                    retire_prf[c] = 6'(bq[idx]);
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/free_list_ckpt.md
Name: free_list_ckpt

Overview:
Parametrised physical-register free list for the rename stage, successor to the single-recover integer free list. Grants up to RENAME_WIDTH lowest-indexed free registers per cycle (all-or-nothing). Adds CKPT_NUM branch checkpoints for selective restore, plus a full architectural flush. Commit-side frees and retires continue while rename is stalled.

Parameters:
PRF_SIZE, 64, number of physical registers
ARCH_REGS, 32, registers busy at reset (identity map p0..p(ARCH_REGS-1))
RENAME_WIDTH, 4, allocation lanes
COMMIT_WIDTH, 4, free/retire lanes
CKPT_NUM, 4, branch checkpoint slots
(derived) PIDX = $clog2(PRF_SIZE), CIDX = $clog2(CKPT_NUM)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  rename stalled; blocks allocation and ckpt_take only
flush  in  1  restore live list from architectural list
free_valid  in  COMMIT_WIDTH  commit frees previous mapping
free_prf  in  COMMIT_WIDTH x PIDX  register freed
retire_valid  in  COMMIT_WIDTH  commit makes destination architectural
retire_prf  in  COMMIT_WIDTH x PIDX  register retired
alloc_req  in  RENAME_WIDTH  per-lane request
alloc_prf  out  RENAME_WIDTH x PIDX  granted register per lane
alloc_ok  out  1  all requests grantable this cycle
ckpt_take  in  1  snapshot into slot ckpt_take_id
ckpt_take_id  in  CIDX  slot to write
ckpt_restore  in  1  restore from slot ckpt_restore_id
ckpt_restore_id  in  CIDX  slot to read
free_count  out  PIDX+1  free registers in live list
double_free  out  1  sticky double-free error (optional feature)

Behaviour:
- State: live bitmap (1 = busy); arch bitmap; CKPT_NUM snapshot bitmaps with valid bits.
- Reset (reset = 0, async): live and arch have bits 0..ARCH_REGS-1 set, others clear; all ckpt valid = 0. Resulting outputs: free_count = PRF_SIZE-ARCH_REGS, double_free = 0.
- free_count = PRF_SIZE - popcount(live), combinational from the register.
- Allocation (combinational from registered live; no same-cycle bypass of frees):
  - n = popcount(alloc_req); alloc_ok = (n <= free_count).
  - The n lowest free indices go to requesting lanes in ascending lane order.
  - Non-requesting lanes output 0; every lane outputs 0 when alloc_ok = 0.
- Frees and retires are applied every cycle regardless of stall:
  - free_prf clears its bit in live, in arch, and in every valid checkpoint.
  - retire_prf sets its bit in arch.
  - Lanes are processed 0..COMMIT_WIDTH-1.
- Update priority at each edge is flush > ckpt_restore > normal.
  - flush: live <= arch after this cycle's retires and frees; all ckpt valid cleared; allocation and ckpt ops discarded.
  - ckpt_restore to a valid slot: live <= slot contents with this cycle's frees cleared; allocation and ckpt_take discarded; slot stays valid.
  - ckpt_restore to an invalid slot: no live update and allocation discarded; frees still apply.
  - normal with stall = 0 and alloc_ok = 1: granted bits set in live.
  - stall = 1 or alloc_ok = 0: no bits are set.
- ckpt_take (stall = 0, no flush or restore): slot <= live_next (including this cycle's grants and frees); valid <= 1. An already-valid slot is overwritten.
- Freeing and allocating the same index in one cycle cannot occur, because grants come from registered live.

Optional Feature:
FREE_LIST_DOUBLE_FREE_CHECK_EN
- Defined: double_free is set on any free_prf whose live bit is already 0, or on duplicate free_prf within one cycle. It stays set until reset. The frees still proceed.
- Undefined: double_free is tied to 0 and no check logic is built.

Test Plan:
1. Reset, then alloc_req = 4'b1111 -> alloc_ok = 1, alloc_prf = {35,34,33,32} (lane3..lane0); next cycle free_count = 28.
2. alloc_req = 4'b1010 from reset state -> lane1 = 32, lane3 = 33, lanes 0 and 2 = 0; free_count 32 -> 30.
3. Allocate all 32, then alloc_req = 4'b0001 -> alloc_ok = 0, alloc_prf = 0, state unchanged. Free p40 with stall = 1 -> next cycle free_count = 1, request grants 40.
4. Alloc 32..35 with ckpt_take id 2, alloc 36..39, ckpt_restore id 2 -> free_count 28; next request grants 36.
5. Take ckpt 1, free p5 in a later cycle, restore 1 -> p5 free after restore; restore to never-taken slot 3 -> live unchanged.
6. Retire 32, free 5, then flush together with alloc_req = 4'b1111 -> no grants; live = arch (p32 busy, p5 free); ckpts invalid. With FREE_LIST_DOUBLE_FREE_CHECK_EN, freeing p5 again sets double_free = 1.
